// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86 fetch unit:
//   - icode constants (I_HALT .. I_POPQ)
//   - status codes (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS)
//   - REG_NONE, the "no register" encoding
//   - fetch FSM state enum
//   - instr_len(): instruction length in bytes for a given icode
// -----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } fetch_state_t;

    // Length in bytes of an instruction, given its icode and the number of
    // bytes in a constant word. Unknown icodes report 1 so that an illegal
    // opcode never causes further memory reads.
    function automatic logic [7:0] instr_len(input logic [3:0] icode, input int word_bytes);
        logic [7:0] wb;
        logic [7:0] len;
        wb = 8'(word_bytes);
        case (icode)
            I_HALT, I_NOP, I_RET:                len = 8'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 8'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 8'd2 + wb;
            I_JXX, I_CALL:                       len = 8'd1 + wb;
            default:                             len = 8'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/y86_fetch_unit_predecode.sv
// -----------------------------------------------------------------------------
// y86_instr_predecode
// Purely combinational classification of an opcode byte.
// Ports:
//   icode, ifun  in   opcode nibbles
//   valid        out  icode/ifun combination is a legal instruction
//   has_regids   out  instruction carries a register-specifier byte
//   has_valC     out  instruction carries a constant word
//   length       out  instruction length in bytes (1 when illegal)
// -----------------------------------------------------------------------------
module y86_instr_predecode
    import y86_pkg::*;
#(
    parameter int WORD_BYTES = 8
) (
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       valid,
    output logic       has_regids,
    output logic       has_valC,
    output logic [7:0] length
);

    always_comb begin
        valid      = 1'b1;
        has_regids = 1'b0;
        has_valC   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                valid = (ifun == 4'h0);
            end
            I_RRMOVQ: begin
                valid      = (ifun <= 4'h6);
                has_regids = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                valid      = (ifun == 4'h0);
                has_regids = 1'b1;
                has_valC   = 1'b1;
            end
            I_OPQ: begin
                valid      = (ifun <= 4'h3);
                has_regids = 1'b1;
            end
            I_JXX: begin
                valid    = (ifun <= 4'h6);
                has_valC = 1'b1;
            end
            I_CALL: begin
                valid    = (ifun == 4'h0);
                has_valC = 1'b1;
            end
            I_PUSHQ, I_POPQ: begin
                valid      = (ifun == 4'h0);
                has_regids = 1'b1;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    // An illegal instruction is treated as one byte long so fetch stops
    // right after the opcode.
    always_comb begin
        length = valid ? instr_len(icode, WORD_BYTES) : 8'd1;
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// -----------------------------------------------------------------------------
// y86_fetch_unit
// Multi-cycle Y86 instruction fetch: reads one byte per cycle from a
// synchronous byte-wide memory and assembles the decoded instruction fields.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, pc_in        begin a fetch at pc_in (accepted only when idle)
//   busy                high whenever not idle
//   imem_rd, imem_addr  byte read request to instruction memory
//   imem_rdata          read data, valid one cycle after its request
//   out_valid/out_ready result handshake toward decode
//   icode, ifun, rA, rB decoded fields
//   valC, valP          constant word and next sequential pc
//   stat                AOK / HLT / ADR / INS
// -----------------------------------------------------------------------------
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] pc_in,
    output logic              busy,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [WORD_W-1:0] valC,
    output logic [WORD_W-1:0] valP,
    output logic [2:0]        stat
);

    localparam int WORD_BYTES = WORD_W / 8;
    localparam logic [WORD_W:0] IMEM_DEPTH = (WORD_W + 1)'(1) << ADDR_W;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [WORD_W-1:0] pc_q;
    logic [7:0]        req_cnt;
    logic              pending;

    logic [7:0]    rcv_idx;
    logic          first_byte;
    logic [3:0]    cur_icode;
    logic [3:0]    cur_ifun;
    logic          pd_valid;
    logic          pd_has_regids;
    logic          pd_has_valC;
    logic [7:0]    pd_len;
    logic [7:0]    vc_start;
    logic [7:0]    vc_off;
    logic [WORD_W:0] byte_addr;
    logic          addr_ok;
    logic          want_req;
    logic          issue;
    logic          adr_err;
    logic          last_byte;
    logic          fetch_done;

    // While byte 0 is arriving its opcode is classified straight off the
    // memory bus, so the length is known in time to suppress the byte-1
    // request of a one-byte instruction.
    always_comb begin
        rcv_idx    = req_cnt - 8'd1;
        first_byte = pending && (req_cnt == 8'd1);
        cur_icode  = first_byte ? imem_rdata[7:4] : icode;
        cur_ifun   = first_byte ? imem_rdata[3:0] : ifun;
    end

    y86_instr_predecode #(
        .WORD_BYTES (WORD_BYTES)
    ) u_predecode (
        .icode      (cur_icode),
        .ifun       (cur_ifun),
        .valid      (pd_valid),
        .has_regids (pd_has_regids),
        .has_valC   (pd_has_valC),
        .length     (pd_len)
    );

    // The byte address carries one bit beyond the pc so that running off the
    // top of memory is detected instead of wrapping back to address 0.
    always_comb begin
        byte_addr  = {1'b0, pc_q} + (WORD_W + 1)'(req_cnt);
        addr_ok    = (byte_addr < IMEM_DEPTH);
        want_req   = (req_cnt == 8'd0) || (req_cnt < pd_len);
        issue      = (state == S_FETCH) && want_req && addr_ok;
        adr_err    = (state == S_FETCH) && want_req && !addr_ok;
        last_byte  = (state == S_FETCH) && pending && (rcv_idx == pd_len - 8'd1);
        fetch_done = adr_err || last_byte;
        vc_start   = pd_has_regids ? 8'd2 : 8'd1;
        vc_off     = rcv_idx - vc_start;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)      state_next = S_FETCH;
            S_FETCH: if (fetch_done) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
        imem_rd   = issue;
        imem_addr = byte_addr[ADDR_W-1:0];
    end

    // Datapath: byte counter, field capture and final status. Fields are
    // cleared at start so absent register bytes read as REG_NONE and an
    // absent constant reads as zero. Nothing changes in DONE, which keeps
    // the result stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            req_cnt <= 8'd0;
            pending <= 1'b0;
            icode   <= I_HALT;
            ifun    <= 4'h0;
            rA      <= REG_NONE;
            rB      <= REG_NONE;
            valC    <= '0;
            valP    <= '0;
            stat    <= STAT_AOK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc_q    <= pc_in;
                        req_cnt <= 8'd0;
                        pending <= 1'b0;
                        icode   <= I_HALT;
                        ifun    <= 4'h0;
                        rA      <= REG_NONE;
                        rB      <= REG_NONE;
                        valC    <= '0;
                    end
                end
                S_FETCH: begin
                    pending <= issue;
                    if (issue) begin
                        req_cnt <= req_cnt + 8'd1;
                    end
                    if (pending) begin
                        if (rcv_idx == 8'd0) begin
                            icode <= imem_rdata[7:4];
                            ifun  <= imem_rdata[3:0];
                        end else if (rcv_idx == 8'd1 && pd_has_regids) begin
                            rA <= imem_rdata[7:4];
                            rB <= imem_rdata[3:0];
                        end
                        if (pd_has_valC && rcv_idx >= vc_start) begin
                            for (int b = 0; b < WORD_BYTES; b++) begin
                                if (vc_off == 8'(b)) begin
                                    valC[b*8 +: 8] <= imem_rdata;
                                end
                            end
                        end
                    end
                    // An address error reports the faulting pc with no
                    // constant; this overrides any byte captured above.
                    if (adr_err) begin
                        stat <= STAT_ADR;
                        valP <= pc_q;
                        valC <= '0;
                    end else if (last_byte) begin
                        valP <= pc_q + WORD_W'(pd_len);
                        if (!pd_valid) begin
                            stat <= STAT_INS;
                        end else if (cur_icode == I_HALT) begin
                            stat <= STAT_HLT;
                        end else begin
                            stat <= STAT_AOK;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
